// File: rtl/inv_pkg.sv
// Shared types and the per-beat operation used by the inv_stream datapath.
// The operation is written once at a fixed maximum width of 64 bits. Callers
// widen their operands to 64 bits and truncate the result back to their own width.
package inv_pkg;

    typedef enum logic [1:0] {
        MODE_INV  = 2'b00,
        MODE_PASS = 2'b01,
        MODE_MASK = 2'b10,
        MODE_REV  = 2'b11
    } mode_e;

    localparam int MAX_W = 64;

    // Bit-reverse works on the full 64-bit word, then shifts the result down so
    // that bit i of the narrow result equals bit (width-1-i) of the narrow input.
    function automatic logic [MAX_W-1:0] apply_op(
        input mode_e            mode,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] mask,
        input int               width
    );
        logic [MAX_W-1:0] rev;
        logic [MAX_W-1:0] y;
        for (int i = 0; i < MAX_W; i++) begin
            rev[i] = a[MAX_W-1-i];
        end
        case (mode)
            MODE_INV:  y = ~a;
            MODE_PASS: y = a;
            MODE_MASK: y = a ^ mask;
            default:   y = rev >> (MAX_W - width);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/inv_stage.sv
// One valid/ready register slice. The slice accepts a new beat when it is
// empty, or when its current beat leaves on the same edge, so bubbles
// collapse. The data output holds its last value while the slice is empty.
module inv_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // The slice can load when it is empty or when it drains this cycle.
    assign in_ready = !out_valid || out_ready;

    // Slice register: capture a new beat, or go empty when drained with nothing behind.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every slice samples pre-edge values and the chain shifts cleanly.
        if (rst) begin
            out_valid <= 1'b0;
            // NOTE: the data register is reset as well, so m_data reads 0 straight after reset.
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/inv_stream.sv
// inv_stream: per-beat selectable bitwise operation (invert, pass, masked
// invert, bit-reverse) followed by a DEPTH-stage valid/ready pipeline with
// full backpressure and an output-beat counter.
// Optional feature: define INV_STREAM_PARITY_EN to add m_parity, the
// registered even parity of m_data.
module inv_stream
    import inv_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic [1:0]       s_mode,
    input  logic [WIDTH-1:0] mask,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] beat_cnt
`ifdef INV_STREAM_PARITY_EN
    ,
    output logic             m_parity
`endif
);

    // The operation is applied before stage 0, so the pipeline only stores results.
    logic [WIDTH-1:0] op_data;
    assign op_data = WIDTH'(apply_op(mode_e'(s_mode), MAX_W'(s_data), MAX_W'(mask), WIDTH));

    // Each generate block owns the handshake signals on both sides of its slice.
    // The slices are chained through those signals. The ready path is
    // combinational from m_ready back to s_ready.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             v_in;
        logic             r_in;
        logic [WIDTH-1:0] d_in;
        logic             v_out;
        logic             r_out;
        logic [WIDTH-1:0] d_out;

        inv_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v_in),
            .in_ready  (r_in),
            .in_data   (d_in),
            .out_valid (v_out),
            .out_ready (r_out),
            .out_data  (d_out)
        );

        if (k == 0) begin : g_head
            assign v_in = s_valid;
            assign d_in = op_data;
        end else begin : g_link
            assign v_in = g_stage[k-1].v_out;
            assign d_in = g_stage[k-1].d_out;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign r_out = m_ready;
        end else begin : g_back
            assign r_out = g_stage[k+1].r_in;
        end
    end

    assign s_ready = g_stage[0].r_in;
    assign m_valid = g_stage[DEPTH-1].v_out;
    assign m_data  = g_stage[DEPTH-1].d_out;

    // Output-beat counter. It wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (m_valid && m_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef INV_STREAM_PARITY_EN
    // Parity is captured together with the beat that enters the last slice, so it is valid with m_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_parity <= 1'b0;
        end else if (g_stage[DEPTH-1].v_in && g_stage[DEPTH-1].r_in) begin
            m_parity <= ^g_stage[DEPTH-1].d_in;
        end
    end
`endif

endmodule

// File: tb/tb_inv_stream.sv
// Directed and scoreboard bench for inv_stream. Three instances share one clock and one reset:
//   dut_a: WIDTH=4, DEPTH=2, CNT_W=16  (directed vectors, backpressure, reset mid-flight)
//   dut_b: WIDTH=8, DEPTH=3, CNT_W=16  (random valid/ready, scoreboard)
//   dut_c: WIDTH=4, DEPTH=2, CNT_W=4   (counter wrap, optional parity)
module tb_inv_stream;
    import inv_pkg::*;

    logic clk;
    logic rst;

    logic       a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [3:0] a_s_data, a_mask, a_m_data;
    logic [1:0] a_s_mode;
    logic [15:0] a_beat_cnt;

    logic       b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [7:0] b_s_data, b_mask, b_m_data;
    logic [1:0] b_s_mode;
    logic [15:0] b_beat_cnt;

    logic       c_s_valid, c_s_ready, c_m_valid, c_m_ready;
    logic [3:0] c_s_data, c_mask, c_m_data;
    logic [1:0] c_s_mode;
    logic [3:0] c_beat_cnt;

`ifdef INV_STREAM_PARITY_EN
    logic a_m_parity, b_m_parity, c_m_parity;
`endif

    int total;
    int passes;
    int fails;

    inv_stream #(.WIDTH(4), .DEPTH(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_mode(a_s_mode), .mask(a_mask),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .beat_cnt(a_beat_cnt)
`ifdef INV_STREAM_PARITY_EN
        , .m_parity(a_m_parity)
`endif
    );

    inv_stream #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_mode(b_s_mode), .mask(b_mask),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .beat_cnt(b_beat_cnt)
`ifdef INV_STREAM_PARITY_EN
        , .m_parity(b_m_parity)
`endif
    );

    inv_stream #(.WIDTH(4), .DEPTH(2), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data), .s_mode(c_s_mode), .mask(c_mask),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data), .beat_cnt(c_beat_cnt)
`ifdef INV_STREAM_PARITY_EN
        , .m_parity(c_m_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference for the 8-bit instance: reverse is built bit by bit from its definition.
    function automatic logic [7:0] model8(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] m);
        logic [7:0] r;
        r = '0;
        case (mode)
            2'b00: r = ~a;
            2'b01: r = a;
            2'b10: r = a ^ m;
            default: for (int i = 0; i < 8; i++) r[i] = a[7-i];
        endcase
        return r;
    endfunction

    initial begin
        logic [7:0] q[$];
        int sent;
        int rcvd;
        int cyc;

        total = 0; passes = 0; fails = 0;
        rst = 1'b1;
        a_s_valid = 0; a_s_data = '0; a_mask = '0; a_s_mode = MODE_PASS; a_m_ready = 1;
        b_s_valid = 0; b_s_data = '0; b_mask = '0; b_s_mode = MODE_PASS; b_m_ready = 0;
        c_s_valid = 0; c_s_data = '0; c_mask = '0; c_s_mode = MODE_PASS; c_m_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        #1;
        check("rst_m_valid", a_m_valid, 0);
        check("rst_m_data", a_m_data, 0);
        check("rst_beat_cnt", a_beat_cnt, 0);
        check("rst_s_ready", a_s_ready, 1);
        check("rst_b_s_ready", b_s_ready, 1);

        // Test 1: invert 4'hA -> 4'h5 with DEPTH=2 latency.
        a_s_valid = 1; a_s_mode = MODE_INV; a_s_data = 4'hA; a_m_ready = 1;
        #1 check("t1_s_ready", a_s_ready, 1);
        @(negedge clk); a_s_valid = 0;
        #1 check("t1_not_yet", a_m_valid, 0);
        @(negedge clk);
        #1 check("t1_m_valid", a_m_valid, 1);
        check("t1_m_data", a_m_data, 4'h5);
        @(negedge clk);
        #1 check("t1_drained", a_m_valid, 0);
        check("t1_beat_cnt", a_beat_cnt, 1);

        // Test 2: masked invert, reverse and pass, streamed back to back.
        @(negedge clk); a_s_valid = 1; a_s_mode = MODE_MASK; a_s_data = 4'hF; a_mask = 4'h3;
        @(negedge clk); a_s_mode = MODE_REV; a_s_data = 4'b0001;
        @(negedge clk); a_s_mode = MODE_PASS; a_s_data = 4'h9;
        #1 check("t2_mask", a_m_data, 4'hC);
        @(negedge clk); a_s_valid = 0;
        #1 check("t2_rev", a_m_data, 4'b1000);
        @(negedge clk);
        #1 check("t2_pass", a_m_data, 4'h9);
        check("t2_pass_valid", a_m_valid, 1);
        @(negedge clk);
        #1 check("t2_drained", a_m_valid, 0);
        check("t2_beat_cnt", a_beat_cnt, 4);

        // Test 3: fill under backpressure, then release.
        @(negedge clk); a_m_ready = 0; a_s_valid = 1; a_s_mode = MODE_INV; a_s_data = 4'h1;
        @(negedge clk); a_s_data = 4'h2;
        #1 check("t3_ready_one_held", a_s_ready, 1);
        @(negedge clk); a_s_data = 4'h3;
        #1 check("t3_full_ready", a_s_ready, 0);
        check("t3_full_valid", a_m_valid, 1);
        check("t3_full_data", a_m_data, 4'hE);
        @(negedge clk);
        #1 check("t3_stall_ready", a_s_ready, 0);
        check("t3_stall_data", a_m_data, 4'hE);
        a_m_ready = 1;
        #1 check("t3_release_ready", a_s_ready, 1);
        @(negedge clk); a_s_valid = 0;
        #1 check("t3_second", a_m_data, 4'hD);
        check("t3_second_valid", a_m_valid, 1);
        @(negedge clk);
        #1 check("t3_third", a_m_data, 4'hC);
        check("t3_third_valid", a_m_valid, 1);
        @(negedge clk);
        #1 check("t3_drained", a_m_valid, 0);
        check("t3_beat_cnt", a_beat_cnt, 7);

        // Test 4: random valid/ready on the 8-bit, 3-deep instance with a scoreboard.
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            @(negedge clk);
            if (sent < 1000) begin
                b_s_valid = 1'($urandom_range(0, 1));
                b_s_data  = 8'($urandom);
                b_mask    = 8'($urandom);
                b_s_mode  = 2'($urandom_range(0, 3));
            end else begin
                b_s_valid = 0;
            end
            b_m_ready = 1'($urandom_range(0, 1));
            #1;
            if (b_m_valid && b_m_ready) begin
                if (q.size() == 0) begin
                    check("t4_unexpected_beat", b_m_data, 8'hxx);
                end else begin
                    check("t4_scoreboard", b_m_data, q.pop_front());
                end
                rcvd++;
            end
            if (b_s_valid && b_s_ready) begin
                q.push_back(model8(b_s_mode, b_s_data, b_mask));
                sent++;
            end
            cyc++;
        end
        check("t4_rcvd", rcvd, 1000);
        @(negedge clk); b_s_valid = 0; b_m_ready = 0;
        #1 check("t4_beat_cnt", b_beat_cnt, 1000);
        check("t4_empty", b_m_valid, 0);

        // Test 6: 17 beats through CNT_W=4 wrap the counter to 1; 4'h7 has odd bit count.
        sent = 0; rcvd = 0; cyc = 0;
        c_s_mode = MODE_PASS; c_s_data = 4'h7; c_m_ready = 1;
        while (rcvd < 17 && cyc < 200) begin
            @(negedge clk);
            c_s_valid = (sent < 17);
            #1;
            if (c_m_valid && c_m_ready) begin
                check("t6_data", c_m_data, 4'h7);
`ifdef INV_STREAM_PARITY_EN
                check("t6_parity", c_m_parity, 1);
`endif
                rcvd++;
            end
            if (c_s_valid && c_s_ready) sent++;
            cyc++;
        end
        check("t6_rcvd", rcvd, 17);
        @(negedge clk); c_s_valid = 0;
        #1 check("t6_beat_cnt_wrap", c_beat_cnt, 1);

        // Test 5: reset with two beats in flight on the 4-bit instance.
        @(negedge clk); a_m_ready = 0; a_s_valid = 1; a_s_mode = MODE_INV; a_s_data = 4'h5;
        @(negedge clk); a_s_data = 4'h6;
        @(negedge clk); a_s_valid = 0; rst = 1;
        #1 check("t5_in_flight", a_m_valid, 1);
        @(negedge clk); rst = 0;
        #1 check("t5_m_valid", a_m_valid, 0);
        check("t5_beat_cnt", a_beat_cnt, 0);
        check("t5_s_ready", a_s_ready, 1);
        check("t5_m_data", a_m_data, 0);
        a_m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("t5_no_stale", a_m_valid, 0);
        end
        check("t5_cnt_after", a_beat_cnt, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
